// File: rtl/pio_irq_pkg.sv
// Shared definitions for the PIO interrupt master: FSM states, PIO register map,
// drop counter and timestamp widths.
package pio_irq_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RD_REQ = 3'd2,
    ST_RD_CAP = 3'd3,
    ST_CLR    = 3'd4,
    ST_PUSH   = 3'd5
  } state_t;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  localparam int DROP_W = 8;
  localparam int TS_W   = 16;

  // Drop counter sticks at all-ones rather than wrapping back to zero
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
    return (&value) ? value : value + DROP_W'(1);
  endfunction

endpackage

// File: rtl/pio_evt_fifo.sv
// Event FIFO for the PIO interrupt master. When full, a pop in the same cycle
// frees the slot so a simultaneous push is accepted; pops on empty are ignored.
module pio_evt_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid    = (count != '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pop_data is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pio_irq_master.sv
// Services PIO edge-capture interrupts over Avalon-MM and queues captured edge vectors.
// Define PIO_IRQ_MASTER_TIMESTAMP_EN to add a 16-bit cycle timestamp (evt_ts) per event.
module pio_irq_master
  import pio_irq_pkg::*;
#(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] MASK_INIT  = 5'h1F,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              irq,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic              evt_valid,
  output logic [WIDTH-1:0]  evt_data,
  input  logic              evt_ready,
  output logic [DROP_W-1:0] drop_cnt
`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   evt_ts
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cap_reg;
  logic             fifo_push;
  logic             fifo_overflow;
  logic             unused_rdata;

  assign unused_rdata = ^avm_readdata;
  assign fifo_push    = (state == ST_PUSH) && (cap_reg != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   state_nxt = ST_IDLE;
      ST_IDLE:   if (irq) state_nxt = ST_RD_REQ;
      ST_RD_REQ: state_nxt = ST_RD_CAP;
      ST_RD_CAP: state_nxt = ST_CLR;
      ST_CLR:    state_nxt = ST_PUSH;
      ST_PUSH:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  // The slave presents read data one cycle after the address, i.e. during RD_CAP
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INIT;
      cap_reg  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RD_CAP) cap_reg <= avm_readdata[WIDTH-1:0];
      if (fifo_overflow) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Bus is decoded from state and forced idle while reset is held
  always_comb begin
    avm_address    = REG_DATA;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = '0;
    if (!reset) begin
      case (state)
        ST_INIT: begin
          avm_address    = REG_MASK;
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_writedata  = 32'(MASK_INIT);
        end
        ST_RD_REQ: begin
          avm_address    = REG_EDGE;
          avm_chipselect = 1'b1;
        end
        ST_CLR: begin
          avm_address    = REG_EDGE;
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
        end
        default: begin
          avm_address    = REG_DATA;
          avm_chipselect = 1'b0;
        end
      endcase
    end
  end

`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
  logic [TS_W-1:0]       ts_cnt;
  logic [TS_W-1:0]       ts_cap;
  logic [TS_W+WIDTH-1:0] fifo_out;

  // Timestamp is taken in the same cycle the edge vector is captured
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= '0;
      ts_cap <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (state == ST_RD_CAP) ts_cap <= ts_cnt;
    end
  end

  pio_evt_fifo #(
    .WIDTH (TS_W + WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({ts_cap, cap_reg}),
    .pop       (evt_ready),
    .pop_data  (fifo_out),
    .valid     (evt_valid),
    .overflow  (fifo_overflow)
  );

  assign evt_data = fifo_out[WIDTH-1:0];
  assign evt_ts   = fifo_out[WIDTH +: TS_W];
`else
  pio_evt_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cap_reg),
    .pop       (evt_ready),
    .pop_data  (evt_data),
    .valid     (evt_valid),
    .overflow  (fifo_overflow)
  );
`endif

endmodule

// File: tb/tb_pio_irq_master.sv
// Bench for pio_irq_master: PIO slave model with a bus-transfer scoreboard and an
// event scoreboard; both queues are filled when stimulus is driven.
module tb_pio_irq_master;
  import pio_irq_pkg::*;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              irq;
  logic [1:0]        avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              evt_valid;
  logic [WIDTH-1:0]  evt_data;
  logic              evt_ready = 1'b0;
  logic [DROP_W-1:0] drop_cnt;
`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
  logic [15:0]       evt_ts;
  logic [15:0]       lastTs = 16'h0;
`endif

  logic [WIDTH-1:0] edge_reg = '0;
  logic [WIDTH-1:0] mask_reg = '0;
  logic [WIDTH-1:0] edge_in = '0;
  logic             edge_stb = 1'b0;
  logic             irq_force = 1'b0;

  logic [35:0]      expBus[$];
  logic [WIDTH-1:0] expEvt[$];
  int expDrop  = 0;
  int checkCnt = 0;
  int passCnt  = 0;
  int popCnt   = 0;

  always #5 clk = ~clk;

  pio_irq_master #(
    .WIDTH      (WIDTH),
    .MASK_INIT  (5'h1F),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .irq            (irq),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .evt_valid      (evt_valid),
    .evt_data       (evt_data),
    .evt_ready      (evt_ready),
    .drop_cnt       (drop_cnt)
`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
    ,
    .evt_ts         (evt_ts)
`endif
  );

  assign irq = (|(edge_reg & mask_reg)) | irq_force;

  // PIO slave: read data one cycle after the address, garbage otherwise
  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n)
      avm_readdata <= (avm_address == REG_EDGE) ? {27'h0, edge_reg} :
                      (avm_address == REG_MASK) ? {27'h0, mask_reg} : 32'h0;
    else
      avm_readdata <= 32'hA5A5_A5B5;
    if (avm_chipselect && !avm_write_n && avm_address == REG_MASK)
      mask_reg <= avm_writedata[WIDTH-1:0];
    if (avm_chipselect && !avm_write_n && avm_address == REG_EDGE)
      edge_reg <= '0;
    else if (edge_stb)
      edge_reg <= edge_reg | edge_in;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard side: every transfer and every popped event is matched in order
  always @(negedge clk) begin
    if (avm_chipselect) begin
      if (expBus.size() == 0)
        checkOutput("bus_unexpected", 64'({avm_chipselect, avm_write_n, avm_address, avm_writedata}), 64'(0));
      else
        checkOutput("bus_tx", 64'({avm_chipselect, avm_write_n, avm_address, avm_writedata}), 64'(expBus.pop_front()));
    end
    if (evt_valid && evt_ready) begin
      popCnt <= popCnt + 1;
      if (expEvt.size() == 0)
        checkOutput("evt_unexpected", 64'({1'b1, evt_data}), 64'(0));
      else
        checkOutput("evt_data", 64'(evt_data), 64'(expEvt.pop_front()));
`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
      checkOutput("evt_ts_mono", 64'(evt_ts > lastTs), 64'(1));
      lastTs <= evt_ts;
`endif
    end
`ifdef PIO_IRQ_MASTER_TIMESTAMP_EN
    if (reset) lastTs <= 16'h0;
`endif
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input bit popInPush);
    bit seen = 1'b0;
    expBus.push_back({1'b1, 1'b1, REG_EDGE, 32'h0});
    expBus.push_back({1'b1, 1'b0, REG_EDGE, 32'h0});
    if (data != '0) begin
      if (expEvt.size() < DEPTH || popInPush) expEvt.push_back(data);
      else if (expDrop < 255) expDrop++;
      edge_in  = data;
      edge_stb = 1'b1;
    end else begin
      irq_force = 1'b1;
    end
    @(posedge clk); #1;
    edge_stb  = 1'b0;
    irq_force = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = avm_chipselect && !avm_write_n && (avm_address == REG_EDGE);
    end
    checkOutput("clr_seen", 64'(seen), 64'(1));
    @(posedge clk); #1;
    if (popInPush) evt_ready = 1'b1;
    @(posedge clk); #1;
    if (popInPush) evt_ready = 1'b0;
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(expDrop));
  endtask

  initial begin
    int n;
    int startPop;
    bit seen;

    repeat (3) @(posedge clk); #1;
    checkOutput("rst_address", 64'(avm_address), 64'(0));
    checkOutput("rst_chipselect", 64'(avm_chipselect), 64'(0));
    checkOutput("rst_write_n", 64'(avm_write_n), 64'(1));
    checkOutput("rst_writedata", 64'(avm_writedata), 64'(0));
    checkOutput("rst_evt_valid", 64'(evt_valid), 64'(0));
    checkOutput("rst_evt_data", 64'(evt_data), 64'(0));
    checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'(0));

    expBus.push_back({1'b1, 1'b0, REG_MASK, 32'h1F});
    reset = 1'b0;
    repeat (6) @(posedge clk); #1;
    checkOutput("mask_written", 64'(mask_reg), 64'(5'h1F));

    $display("[TB] service latency with slave edge 5'b00100");
    expBus.push_back({1'b1, 1'b1, REG_EDGE, 32'h0});
    expBus.push_back({1'b1, 1'b0, REG_EDGE, 32'h0});
    expEvt.push_back(5'h04);
    evt_ready = 1'b1;
    edge_in   = 5'b00100;
    edge_stb  = 1'b1;
    @(posedge clk); #1;
    edge_stb = 1'b0;
    n = 0;
    while (n < 20 && !evt_valid) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("latency", 64'(n), 64'(5));
    checkOutput("evt_data_first", 64'(evt_data), 64'(5'h04));
    repeat (3) @(posedge clk); #1;
    evt_ready = 1'b0;
    checkOutput("empty_after_pop", 64'(evt_valid), 64'(0));

    $display("[TB] six events with consumer stalled");
    for (int d = 1; d <= 6; d++) applyStimulus(WIDTH'(d), 1'b0);
    checkOutput("full_valid", 64'(evt_valid), 64'(1));
    checkOutput("full_head", 64'(evt_data), 64'(1));

    $display("[TB] push into full FIFO with pop in the same cycle");
    applyStimulus(5'h07, 1'b1);
    startPop  = popCnt;
    evt_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    evt_ready = 1'b0;
    checkOutput("drained_count", 64'(popCnt - startPop), 64'(4));
    checkOutput("empty_after_drain", 64'(evt_valid), 64'(0));

    $display("[TB] spurious interrupt");
    applyStimulus('0, 1'b0);
    checkOutput("spurious_no_evt", 64'(evt_valid), 64'(0));

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 258; i++) applyStimulus(WIDTH'((i % 31) + 1), 1'b0);
    checkOutput("drop_saturated", 64'(drop_cnt), 64'(8'hFF));

    $display("[TB] reset during CLR");
    expBus.push_back({1'b1, 1'b1, REG_EDGE, 32'h0});
    edge_in  = 5'h09;
    edge_stb = 1'b1;
    @(posedge clk); #1;
    edge_stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = avm_chipselect && avm_write_n && (avm_address == REG_EDGE);
    end
    checkOutput("rd_seen", 64'(seen), 64'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    expEvt.delete();
    expDrop = 0;
    #1;
    checkOutput("rst_mid_chipselect", 64'(avm_chipselect), 64'(0));
    @(posedge clk); #1;
    checkOutput("rst2_address", 64'(avm_address), 64'(0));
    checkOutput("rst2_write_n", 64'(avm_write_n), 64'(1));
    checkOutput("rst2_writedata", 64'(avm_writedata), 64'(0));
    checkOutput("rst2_evt_valid", 64'(evt_valid), 64'(0));
    checkOutput("rst2_evt_data", 64'(evt_data), 64'(0));
    checkOutput("rst2_drop_cnt", 64'(drop_cnt), 64'(0));
    expBus.push_back({1'b1, 1'b0, REG_MASK, 32'h1F});
    expBus.push_back({1'b1, 1'b1, REG_EDGE, 32'h0});
    expBus.push_back({1'b1, 1'b0, REG_EDGE, 32'h0});
    expEvt.push_back(5'h09);
    reset     = 1'b0;
    evt_ready = 1'b1;
    startPop  = popCnt;
    n = 0;
    while (n < 30 && popCnt == startPop) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("post_reset_evt", 64'(popCnt - startPop), 64'(1));
    evt_ready = 1'b0;

    repeat (4) @(posedge clk); #1;
    checkOutput("bus_q_drained", 64'(expBus.size()), 64'(0));
    checkOutput("evt_q_drained", 64'(expEvt.size()), 64'(0));
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run did not reach its summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pio_irq_master.md
PIO_IRQ_MASTER -- requirements
Module: pio_irq_master

Interface
REQ-001 SHALL have parameter WIDTH, default 5: number of PIO edge-capture bits serviced.
REQ-002 SHALL have parameter MASK_INIT, default 5'h1F: value written to the PIO irq_mask register after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two): event FIFO entries.
REQ-004 SHALL have clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have irq  input  1  PIO interrupt request, level.
REQ-007 SHALL have avm_address  output  2  Avalon-MM word address to the PIO slave.
REQ-008 SHALL have avm_chipselect  output  1  transfer strobe.
REQ-009 SHALL have avm_write_n  output  1  low for write, high for read.
REQ-010 SHALL have avm_writedata  output  32  write data.
REQ-011 SHALL have avm_readdata  input  32  PIO read data; valid one cycle after address is presented; no waitrequest.
REQ-012 SHALL have evt_valid  output  1  event FIFO not empty.
REQ-013 SHALL have evt_data  output  WIDTH  oldest captured edge vector.
REQ-014 SHALL have evt_ready  input  1  consumer pop; pop when evt_valid && evt_ready.
REQ-015 SHALL have drop_cnt  output  8  events lost to a full FIFO, saturating at 8'hFF.

Function
REQ-016 SHALL run FSM states INIT, IDLE, RD_REQ, RD_CAP, CLR, PUSH.
REQ-017 INIT SHALL drive one write cycle: address 2, chipselect 1, write_n 0, writedata = zero-extended MASK_INIT; next state IDLE.
REQ-018 IDLE SHALL hold chipselect 0, write_n 1, address 0; on irq==1 go to RD_REQ.
REQ-019 RD_REQ SHALL drive address 3, chipselect 1, write_n 1 for one cycle; next state RD_CAP.
REQ-020 RD_CAP SHALL register avm_readdata[WIDTH-1:0] into cap_reg, bus idle; next state CLR.
REQ-021 CLR SHALL drive one write cycle: address 3, chipselect 1, write_n 0, writedata 0; next state PUSH.
REQ-022 PUSH SHALL enqueue cap_reg when cap_reg != 0 and FIFO not full; cap_reg==0 (spurious) SHALL be discarded with no count; next state IDLE.
REQ-023 PUSH with FIFO full and cap_reg != 0 SHALL discard cap_reg and increment drop_cnt unless already 8'hFF.
REQ-024 The IRQ service latency SHALL be 5 cycles from irq sampled high in IDLE to the event being visible on evt_valid.
REQ-025 Simultaneous push and pop with the FIFO full SHALL pop first, so the push succeeds without a drop.
REQ-026 A pop on an empty FIFO SHALL be ignored.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Edges arriving between RD_REQ and CLR SHALL be cleared by the slave and lost.
REQ-029 No transfer SHALL be issued outside INIT, RD_REQ and CLR.

Reset
REQ-030 Reset SHALL force state INIT and cap_reg 0.
REQ-031 Reset SHALL empty the FIFO (evt_valid 0, evt_data 0) and clear drop_cnt to 0.
REQ-032 Reset SHALL drive avm_address 0, avm_chipselect 0, avm_write_n 1 and avm_writedata 0.
REQ-033 Reset asserted mid-sequence SHALL abandon the transfer and rerun INIT on the first cycle after release.

Configuration
REQ-034 With PIO_IRQ_MASTER_TIMESTAMP_EN defined, the block SHALL add output evt_ts[15:0].
REQ-035 With that macro, a free-running 16-bit cycle counter SHALL be reset to 0 and wrap at 16'hFFFF.
REQ-036 With that macro, the counter value sampled in RD_CAP SHALL be stored alongside each event and output with evt_data.
REQ-037 Without that macro, the block SHALL have neither the port nor the counter.

Structure
REQ-038 A shared package pio_irq_pkg SHALL hold the FSM state enum, the PIO register address constants (DATA=0, MASK=2, EDGE=3) and the drop counter width.
REQ-039 The FIFO SHALL be the sub-module pio_evt_fifo (width, depth parameters, with simultaneous push/pop handling).

Verification
REQ-040 Release reset -> next cycle a write to address 2 with data 32'h1F; no other transfer until irq.
REQ-041 Slave model returns 5'b00100 on an address-3 read after irq rises -> read, then a write of 0 to address 3, then evt_valid=1 with evt_data=5'h04 exactly 5 cycles after irq is sampled.
REQ-042 evt_ready held 0 and 6 IRQs with data 1..6 -> FIFO holds 1,2,3,4 and drop_cnt=2; popping returns 1,2,3,4 in order.
REQ-043 FIFO full and evt_ready=1 in the PUSH cycle -> no drop, and count stays 4.
REQ-044 irq pulses while the slave returns 0 -> a read and clear are issued, no event is enqueued and drop_cnt is unchanged.
REQ-045 Reset asserted during CLR -> all outputs return to reset values, then the INIT write is repeated; with TIMESTAMP_EN the evt_ts values increase monotonically across events.
